// File: rtl/sbqm_pkg.sv
// Shared constants and types for the queue-management block.
// The wait-time table is indexed by {tellers, count}.
package sbqm_pkg;

   localparam int unsigned MAX_CUST = 7;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned WT_W     = 5;
   localparam int unsigned TEL_W    = 2;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [WT_W-1:0]  wt_t;
   typedef logic [TEL_W-1:0] tel_t;

   // floor(3*(P+T-1)/T), zero when P == 0; the tellers == 0 row repeats the one-teller row
   localparam wt_t WTIME_LUT [2**(TEL_W+CNT_W)] = '{
      5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15, 5'd18, 5'd21,
      5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15, 5'd18, 5'd21,
      5'd0, 5'd3, 5'd4, 5'd6, 5'd7,  5'd9,  5'd10, 5'd12,
      5'd0, 5'd3, 5'd4, 5'd5, 5'd6,  5'd7,  5'd8,  5'd9
   };

endpackage

// File: rtl/sbqm_sensor_edge.sv
// Photocell front end: 2-flop synchroniser, debouncer and a one-cycle pulse
// when the debounced level falls (the customer has cleared the beam).
module sbqm_sensor_edge #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sensor,
   output logic fall
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q;
   logic          fall_q;
   logic [CW-1:0] deb_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         fall_q  <= 1'b0;
         deb_q   <= '0;
      end else begin
         sync1_q <= sensor;
         sync2_q <= sync1_q;
         fall_q  <= 1'b0;
         if (sync2_q == level_q) begin
            deb_q <= '0;
         end else if (deb_q == CW'(DEB_CYCLES - 1)) begin
            // Pulse is registered together with the level so the counter sees it next edge
            level_q <= sync2_q;
            deb_q   <= '0;
            fall_q  <= level_q;
         end else begin
            deb_q <= deb_q + CW'(1);
         end
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/sbqm_queue_ctrl.sv
// Bank queue controller: counts customers between the entry and exit photocells
// and publishes occupancy flags plus an estimated wait time.
module sbqm_queue_ctrl
   import sbqm_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned MAX_CUST   = sbqm_pkg::MAX_CUST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             back_sensor,
   input  logic             front_sensor,
   input  logic [TEL_W-1:0] tellers,
   output logic [CNT_W-1:0] pcount,
   output logic [WT_W-1:0]  wtime,
   output logic             full,
   output logic             empty,
   output logic             ovf_err,
   output logic             udf_err
);

   localparam cnt_t MaxCnt = cnt_t'(MAX_CUST);

   logic arrive, depart;
   cnt_t cnt_q, cnt_d;
   wt_t  wtime_q;
   logic full_q, empty_q, ovf_q, ovf_d, udf_q, udf_d;

   sbqm_sensor_edge #(.DEB_CYCLES(DEB_CYCLES)) u_back (
      .clk    (clk),
      .rst    (rst),
      .sensor (back_sensor),
      .fall   (arrive)
   );

   sbqm_sensor_edge #(.DEB_CYCLES(DEB_CYCLES)) u_front (
      .clk    (clk),
      .rst    (rst),
      .sensor (front_sensor),
      .fall   (depart)
   );

   // Simultaneous arrive and depart cancel out without an error
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      udf_d = 1'b0;
      if (arrive && !depart) begin
         if (cnt_q == MaxCnt) ovf_d = 1'b1;
         else                 cnt_d = cnt_q + cnt_t'(1);
      end else if (depart && !arrive) begin
         if (cnt_q == '0) udf_d = 1'b1;
         else             cnt_d = cnt_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= '0;
         wtime_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         wtime_q <= WTIME_LUT[{tellers, cnt_d}];
         full_q  <= (cnt_d == MaxCnt);
         empty_q <= (cnt_d == '0);
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign pcount  = cnt_q;
   assign wtime   = wtime_q;
   assign full    = full_q;
   assign empty   = empty_q;
   assign ovf_err = ovf_q;
   assign udf_err = udf_q;

endmodule

// File: doc/sbqm_queue_ctrl.md
SBQM_QUEUE_CTRL -- requirements
Module: sbqm_queue_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of consecutive stable synchronised samples required before a sensor level is accepted.
REQ-002 Parameter MAX_CUST, default 7: queue capacity in customers.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low; 0 = reset.
REQ-005 back_sensor  in  1  entry photocell, asynchronous; 1 = beam blocked.
REQ-006 front_sensor  in  1  exit photocell, asynchronous; 1 = beam blocked.
REQ-007 tellers  in  2  number of active tellers; 0 is treated as 1.
REQ-008 pcount  out  3  customers currently in queue, 0..MAX_CUST.
REQ-009 wtime  out  5  estimated wait time in minutes.
REQ-010 full  out  1  high iff pcount == MAX_CUST.
REQ-011 empty  out  1  high iff pcount == 0.
REQ-012 ovf_err  out  1  one-cycle pulse; arrival rejected because the queue is full.
REQ-013 udf_err  out  1  one-cycle pulse; departure rejected because the queue is empty.

Function
REQ-014 Each sensor SHALL pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB_CYCLES consecutive equal synchronised samples.
REQ-015 A falling edge of the debounced level (customer has cleared the beam) SHALL produce a one-cycle event pulse: arrive for back_sensor, depart for front_sensor.
REQ-016 Sensor glitches shorter than DEB_CYCLES cycles SHALL produce no event.
REQ-017 Latency from the first clock edge that samples a valid sensor level change to the pcount update SHALL be exactly DEB_CYCLES+3 edges, identical for both sensors.
REQ-018 Update rules: arrive only: pcount+1; depart only: pcount-1; both in the same cycle: pcount unchanged, no error pulse.
REQ-019 An arrive when pcount == MAX_CUST (with no simultaneous depart) SHALL leave pcount unchanged and pulse ovf_err.
REQ-020 A depart when pcount == 0 (with no simultaneous arrive) SHALL leave pcount unchanged and pulse udf_err.
REQ-021 pcount SHALL never wrap.
REQ-022 wtime SHALL be 0 when the count is 0; otherwise wtime = floor(3*(P+T-1)/T), where P = count and T = effective tellers (1..3).
REQ-023 wtime SHALL be registered and computed from the next-state count and the current tellers, so wtime changes on the same edge as pcount.
REQ-024 A change on tellers SHALL be reflected in wtime on the next edge.
REQ-025 full and empty SHALL be registered and consistent with pcount in every cycle.

Reset
REQ-026 While rst == 0 at a rising edge, the block SHALL set pcount=0, wtime=0, full=0, empty=1, ovf_err=0 and udf_err=0.
REQ-027 Reset SHALL also clear the synchronisers, the debounce counters and the debounced levels to 0.
REQ-028 Pending events interrupted by reset SHALL be discarded.
REQ-029 A sensor held at 1 through reset release and then released SHALL produce exactly one event once debounced.

Structure
REQ-030 Shared package sbqm_pkg SHALL hold MAX_CUST, the count width (3), the wtime width (5), the teller width (2) and the wtime lookup constant indexed by {T,P}.
REQ-031 Sub-module sbqm_sensor_edge (synchroniser + debouncer + falling-edge pulse) SHALL be instantiated once per sensor.
REQ-032 The top level SHALL contain only the counter, the flags and the wtime register.

Verification (DEB_CYCLES=4)
REQ-033 Reset, then 3 back_sensor pulses of 10 cycles high each with tellers=1 -> pcount=3, wtime=9, empty=0; each update occurs exactly 7 edges after the sampled falling edge.
REQ-034 7 arrivals then 1 more arrival -> pcount stays 7, full=1, one ovf_err pulse; then tellers=3 -> wtime=9 on the next edge.
REQ-035 From pcount=0, one front_sensor pulse -> udf_err pulses once, pcount=0, empty=1.
REQ-036 pcount=4, with back and front falling edges aligned to the same cycle -> pcount stays 4, no error pulses; a 3-cycle glitch on back_sensor -> no change.
REQ-037 pcount=5, tellers=2; assert rst=0 for 1 cycle mid-debounce -> pcount=0, wtime=0, empty=1; the interrupted event does not appear after release.
